// File: rtl/wb_trace_checker.sv
// ---------------------------------------------------------------------------
// wb_trace_checker
//
// Purpose:
//   Golden-trace writeback monitor for the pipelined CPU. A list of expected
//   {PC, writeback data} pairs is loaded while idle. After Start, each
//   committed writeback is compared against the next golden entry in order.
//   The run ends in one of three ways:
//     - complete: the last loaded entry has been compared
//     - timeout:  TIMEOUT cycles have been spent running
//     - halt:     the PC has stayed the same for HALT_CYC cycles in a row
//                 with no commit
//   The result stays on the outputs until Clear. Clear keeps the loaded trace,
//   so a rerun only needs another Start.
//
// Ports:
//   Clk, Reset          clock (rising edge), asynchronous active-low reset
//   Clear               DONE -> IDLE, zeroes results, keeps the loaded trace
//   LoadEn/LoadPC/LoadData  append one golden entry (IDLE only)
//   Start               IDLE -> RUN (needs at least one entry loaded)
//   PCVal, WriteDataOut, WriteValid   CPU writeback being monitored
//   Busy, Done, Pass    run status, all registered
//   StopCause           0 complete, 1 halt, 2 timeout, 3 none
//   MismatchCount       saturating count of miscompares
//   FirstBadIdx         trace index of the first miscompare
//   CycleCount          saturating count of RUN cycles
//   EntryCount          number of golden entries loaded
//   LoadOverflow        sticky, set by LoadEn while the trace is full
// ---------------------------------------------------------------------------
module wb_trace_checker #(
  parameter int DATA_W   = 32,
  parameter int PC_W     = 32,
  parameter int DEPTH    = 64,
  parameter int HALT_CYC = 8,
  parameter int TIMEOUT  = 1024,
  parameter int CNT_W    = 16
) (
  input  logic                       Clk,
  input  logic                       Reset,
  input  logic                       Clear,
  input  logic                       LoadEn,
  input  logic [PC_W-1:0]            LoadPC,
  input  logic [DATA_W-1:0]          LoadData,
  input  logic                       Start,
  input  logic [PC_W-1:0]            PCVal,
  input  logic [DATA_W-1:0]          WriteDataOut,
  input  logic                       WriteValid,
  output logic                       Busy,
  output logic                       Done,
  output logic                       Pass,
  output logic [1:0]                 StopCause,
  output logic [CNT_W-1:0]           MismatchCount,
  output logic [$clog2(DEPTH)-1:0]   FirstBadIdx,
  output logic [CNT_W-1:0]           CycleCount,
  output logic [$clog2(DEPTH):0]     EntryCount,
  output logic                       LoadOverflow
);

  localparam int IW = $clog2(DEPTH);
  localparam int EW = IW + 1;
  localparam int HW = $clog2(HALT_CYC + 1);

  localparam logic [EW-1:0]    DEPTH_C   = EW'(DEPTH);
  localparam logic [HW-1:0]    HALT_C    = HW'(HALT_CYC);
  localparam logic [CNT_W-1:0] TIMEOUT_C = CNT_W'(TIMEOUT);

  localparam logic [1:0] CAUSE_COMPLETE = 2'd0;
  localparam logic [1:0] CAUSE_HALT     = 2'd1;
  localparam logic [1:0] CAUSE_TIMEOUT  = 2'd2;
  localparam logic [1:0] CAUSE_NONE     = 2'd3;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_DONE = 2'd2
  } state_t;

  state_t             r_state;
  state_t             w_stateNext;

  logic [PC_W-1:0]    r_ramPC   [DEPTH];
  logic [DATA_W-1:0]  r_ramData [DEPTH];

  logic [IW-1:0]      r_idx;
  logic [HW-1:0]      r_haltCnt;
  logic [PC_W-1:0]    r_prevPC;
  logic               r_busy;
  logic               r_done;
  logic               r_pass;
  logic [1:0]         r_cause;
  logic [CNT_W-1:0]   r_misCnt;
  logic [IW-1:0]      r_badIdx;
  logic [CNT_W-1:0]   r_cycCnt;
  logic [EW-1:0]      r_entryCnt;
  logic               r_loadOvf;

  logic               w_doLoad;
  logic               w_loadFull;
  logic               w_doStart;
  logic               w_doClear;
  logic               w_mismatch;
  logic [EW-1:0]      w_lastIdx;
  logic               w_lastCmp;
  logic [CNT_W-1:0]   w_cycNext;
  logic [CNT_W-1:0]   w_misNext;
  logic [HW-1:0]      w_haltNext;
  logic [1:0]         w_endCause;

  // Golden entry for the current trace position, compared as one wide word.
  assign w_mismatch = {PCVal, WriteDataOut} != {r_ramPC[r_idx], r_ramData[r_idx]};
  assign w_lastIdx  = r_entryCnt - 1'b1;

  // State register.
  always_ff @(posedge Clk or negedge Reset) begin
    if (!Reset) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_stateNext;
    end
  end

  // Next-state logic and per-cycle run decisions. The end-of-run checks are
  // tested in priority order: the last compare beats timeout, which beats
  // halt, so a run that finishes exactly on its final cycle still counts as
  // complete.
  always_comb begin
    w_stateNext = r_state;
    w_doLoad    = 1'b0;
    w_loadFull  = 1'b0;
    w_doStart   = 1'b0;
    w_doClear   = 1'b0;
    w_lastCmp   = 1'b0;
    w_cycNext   = r_cycCnt;
    w_misNext   = r_misCnt;
    w_haltNext  = r_haltCnt;
    w_endCause  = CAUSE_NONE;
    case (r_state)
      S_IDLE: begin
        if (LoadEn) begin
          if (r_entryCnt == DEPTH_C) begin
            w_loadFull = 1'b1;
          end else begin
            w_doLoad = 1'b1;
          end
        end else if (Start && (r_entryCnt != '0)) begin
          w_doStart   = 1'b1;
          w_stateNext = S_RUN;
        end
      end
      S_RUN: begin
        w_cycNext = (r_cycCnt == '1) ? r_cycCnt : r_cycCnt + 1'b1;
        if (WriteValid) begin
          w_haltNext = '0;
          w_lastCmp  = ({1'b0, r_idx} == w_lastIdx);
          if (w_mismatch && (r_misCnt != '1)) begin
            w_misNext = r_misCnt + 1'b1;
          end
        end else if (PCVal == r_prevPC) begin
          w_haltNext = r_haltCnt + 1'b1;
        end else begin
          w_haltNext = '0;
        end
        if (w_lastCmp) begin
          w_endCause  = CAUSE_COMPLETE;
          w_stateNext = S_DONE;
        end else if (w_cycNext >= TIMEOUT_C) begin
          w_endCause  = CAUSE_TIMEOUT;
          w_stateNext = S_DONE;
        end else if (!WriteValid && (w_haltNext == HALT_C)) begin
          w_endCause  = CAUSE_HALT;
          w_stateNext = S_DONE;
        end
      end
      S_DONE: begin
        if (Clear) begin
          w_doClear   = 1'b1;
          w_stateNext = S_IDLE;
        end
      end
      default: begin
        w_stateNext = S_IDLE;
      end
    endcase
  end

  // Trace storage has no reset; entries beyond EntryCount are simply unused.
  always_ff @(posedge Clk) begin
    if (w_doLoad) begin
      r_ramPC[r_entryCnt[IW-1:0]]   <= LoadPC;
      r_ramData[r_entryCnt[IW-1:0]] <= LoadData;
    end
  end

  // Result and bookkeeping registers. Busy/Done are registered from the next
  // state so they line up with the state register.
  always_ff @(posedge Clk or negedge Reset) begin
    if (!Reset) begin
      r_idx      <= '0;
      r_haltCnt  <= '0;
      r_prevPC   <= '0;
      r_busy     <= 1'b0;
      r_done     <= 1'b0;
      r_pass     <= 1'b0;
      r_cause    <= CAUSE_NONE;
      r_misCnt   <= '0;
      r_badIdx   <= '0;
      r_cycCnt   <= '0;
      r_entryCnt <= '0;
      r_loadOvf  <= 1'b0;
    end else begin
      r_prevPC <= PCVal;
      r_busy   <= (w_stateNext == S_RUN);
      r_done   <= (w_stateNext == S_DONE);
      if (w_doLoad) begin
        r_entryCnt <= r_entryCnt + 1'b1;
      end
      if (w_loadFull) begin
        r_loadOvf <= 1'b1;
      end
      if (w_doStart || w_doClear) begin
        r_idx     <= '0;
        r_haltCnt <= '0;
        r_pass    <= 1'b0;
        r_cause   <= CAUSE_NONE;
        r_misCnt  <= '0;
        r_badIdx  <= '0;
        r_cycCnt  <= '0;
      end
      if (r_state == S_RUN) begin
        r_cycCnt  <= w_cycNext;
        r_haltCnt <= w_haltNext;
        r_misCnt  <= w_misNext;
        if (WriteValid) begin
          r_idx <= r_idx + 1'b1;
          if (w_mismatch && (r_misCnt == '0)) begin
            r_badIdx <= r_idx;
          end
        end
        if (w_stateNext == S_DONE) begin
          r_cause <= w_endCause;
          r_pass  <= (w_endCause == CAUSE_COMPLETE) && (w_misNext == '0);
        end
      end
    end
  end

  assign Busy          = r_busy;
  assign Done          = r_done;
  assign Pass          = r_pass;
  assign StopCause     = r_cause;
  assign MismatchCount = r_misCnt;
  assign FirstBadIdx   = r_badIdx;
  assign CycleCount    = r_cycCnt;
  assign EntryCount    = r_entryCnt;
  assign LoadOverflow  = r_loadOvf;

endmodule

// File: tb/tb_wb_trace_checker.sv
// ---------------------------------------------------------------------------
// tb_wb_trace_checker
//
// Purpose:
//   Self-checking bench for wb_trace_checker built with DEPTH=4, HALT_CYC=8
//   and TIMEOUT=20. A table of per-cycle vectors covers loading, matching and
//   mismatching runs, Clear/rerun and load overflow. Hand-written sequences
//   cover halt detection, timeout, commit coincident with timeout, and reset
//   in the middle of a run.
// ---------------------------------------------------------------------------
module tb_wb_trace_checker;

  localparam int DW  = 32;
  localparam int PW  = 32;
  localparam int DEP = 4;
  localparam int CW  = 16;

  logic           Clk = 1'b0;
  logic           Reset;
  logic           Clear;
  logic           LoadEn;
  logic [PW-1:0]  LoadPC;
  logic [DW-1:0]  LoadData;
  logic           Start;
  logic [PW-1:0]  PCVal;
  logic [DW-1:0]  WriteDataOut;
  logic           WriteValid;
  logic           Busy;
  logic           Done;
  logic           Pass;
  logic [1:0]     StopCause;
  logic [CW-1:0]  MismatchCount;
  logic [1:0]     FirstBadIdx;
  logic [CW-1:0]  CycleCount;
  logic [2:0]     EntryCount;
  logic           LoadOverflow;

  int checks   = 0;
  int failures = 0;

  logic [31:0] tPC [4] = '{32'h0, 32'h4, 32'h8, 32'hC};
  logic [31:0] tD  [4] = '{32'h11, 32'h22, 32'h5, 32'h44};

  typedef struct {
    logic        ld;
    logic [31:0] ldPC;
    logic [31:0] ldData;
    logic        st;
    logic        clr;
    logic        wv;
    logic [31:0] pc;
    logic [31:0] wd;
    logic [42:0] exp;
  } vec_t;

  vec_t vecs [25];

  wb_trace_checker #(
    .DATA_W(DW), .PC_W(PW), .DEPTH(DEP), .HALT_CYC(8), .TIMEOUT(20), .CNT_W(CW)
  ) dut (
    .Clk(Clk), .Reset(Reset), .Clear(Clear), .LoadEn(LoadEn), .LoadPC(LoadPC),
    .LoadData(LoadData), .Start(Start), .PCVal(PCVal), .WriteDataOut(WriteDataOut),
    .WriteValid(WriteValid), .Busy(Busy), .Done(Done), .Pass(Pass),
    .StopCause(StopCause), .MismatchCount(MismatchCount), .FirstBadIdx(FirstBadIdx),
    .CycleCount(CycleCount), .EntryCount(EntryCount), .LoadOverflow(LoadOverflow)
  );

  // Free-running 10-unit clock.
  always #5 Clk = ~Clk;

  task automatic tick;
    @(posedge Clk);
    #1;
  endtask

  task automatic applyStimulus(input logic ld, input logic [31:0] ldPC, input logic [31:0] ldData,
                               input logic st, input logic clr, input logic wv,
                               input logic [31:0] pc, input logic [31:0] wd);
    LoadEn       = ld;
    LoadPC       = ldPC;
    LoadData     = ldData;
    Start        = st;
    Clear        = clr;
    WriteValid   = wv;
    PCVal        = pc;
    WriteDataOut = wd;
  endtask

  task automatic checkOutput(input string name, input logic [63:0] act, input logic [63:0] req);
    checks++;
    if (act !== req) begin
      failures++;
      $display("[TB] FAIL %s actual=0x%0h required=0x%0h", name, act, req);
    end
  endtask

  function automatic logic [42:0] packExp(input logic busy, input logic done, input logic pass,
                                          input logic [1:0] cause, input logic [15:0] mis,
                                          input logic [1:0] bad, input logic [15:0] cyc,
                                          input logic [2:0] ent, input logic ovf);
    return {busy, done, pass, cause, mis, bad, cyc, ent, ovf};
  endfunction

  function automatic logic [42:0] observed();
    return {Busy, Done, Pass, StopCause, MismatchCount, FirstBadIdx, CycleCount, EntryCount, LoadOverflow};
  endfunction

  function automatic vec_t mk(input logic ld, input logic [31:0] ldPC, input logic [31:0] ldData,
                              input logic st, input logic clr, input logic wv,
                              input logic [31:0] pc, input logic [31:0] wd, input logic [42:0] exp);
    vec_t v;
    v.ld = ld; v.ldPC = ldPC; v.ldData = ldData; v.st = st; v.clr = clr;
    v.wv = wv; v.pc = pc; v.wd = wd; v.exp = exp;
    return v;
  endfunction

  task automatic idleCycle(input logic [31:0] pc);
    applyStimulus(0, 0, 0, 0, 0, 0, pc, 0);
    tick();
  endtask

  task automatic commit(input logic [31:0] pc, input logic [31:0] wd);
    applyStimulus(0, 0, 0, 0, 0, 1, pc, wd);
    tick();
  endtask

  task automatic pulseStart;
    applyStimulus(0, 0, 0, 1, 0, 0, 0, 0);
    tick();
  endtask

  task automatic pulseClear;
    applyStimulus(0, 0, 0, 0, 1, 0, 0, 0);
    tick();
  endtask

  // Starts a run, commits the whole golden trace, and checks a clean pass.
  task automatic runCleanTrace(input string tag);
    pulseStart();
    for (int k = 0; k < 4; k++) commit(tPC[k], tD[k]);
    checkOutput({tag, "_result"}, 64'(observed()), 64'(packExp(0, 1, 1, 0, 0, 0, 4, 4, 0)));
  endtask

  initial begin
    int n;

    // Table: loading, matching run, mismatching run, overflow, PC mismatch.
    vecs[0]  = mk(1, 32'h0, 32'h11, 0, 0, 0, 0, 0, packExp(0, 0, 0, 3, 0, 0, 0, 1, 0));
    vecs[1]  = mk(1, 32'h4, 32'h22, 0, 0, 0, 0, 0, packExp(0, 0, 0, 3, 0, 0, 0, 2, 0));
    vecs[2]  = mk(1, 32'h8, 32'h05, 0, 0, 0, 0, 0, packExp(0, 0, 0, 3, 0, 0, 0, 3, 0));
    vecs[3]  = mk(1, 32'hC, 32'h44, 0, 0, 0, 0, 0, packExp(0, 0, 0, 3, 0, 0, 0, 4, 0));
    vecs[4]  = mk(0, 0, 0, 1, 0, 0, 32'h100, 0,  packExp(1, 0, 0, 3, 0, 0, 0, 4, 0));
    vecs[5]  = mk(0, 0, 0, 0, 0, 1, 32'h0, 32'h11, packExp(1, 0, 0, 3, 0, 0, 1, 4, 0));
    vecs[6]  = mk(0, 0, 0, 0, 0, 1, 32'h4, 32'h22, packExp(1, 0, 0, 3, 0, 0, 2, 4, 0));
    vecs[7]  = mk(0, 0, 0, 0, 0, 1, 32'h8, 32'h05, packExp(1, 0, 0, 3, 0, 0, 3, 4, 0));
    vecs[8]  = mk(0, 0, 0, 0, 0, 1, 32'hC, 32'h44, packExp(0, 1, 1, 0, 0, 0, 4, 4, 0));
    vecs[9]  = mk(1, 32'h10, 32'h1, 0, 0, 1, 32'hC, 32'h99, packExp(0, 1, 1, 0, 0, 0, 4, 4, 0));
    vecs[10] = mk(0, 0, 0, 0, 1, 0, 0, 0,        packExp(0, 0, 0, 3, 0, 0, 0, 4, 0));
    vecs[11] = mk(0, 0, 0, 1, 0, 0, 0, 0,        packExp(1, 0, 0, 3, 0, 0, 0, 4, 0));
    vecs[12] = mk(0, 0, 0, 0, 0, 1, 32'h0, 32'h11, packExp(1, 0, 0, 3, 0, 0, 1, 4, 0));
    vecs[13] = mk(0, 0, 0, 0, 0, 1, 32'h4, 32'h22, packExp(1, 0, 0, 3, 0, 0, 2, 4, 0));
    vecs[14] = mk(0, 0, 0, 0, 0, 1, 32'h8, 32'h06, packExp(1, 0, 0, 3, 1, 2, 3, 4, 0));
    vecs[15] = mk(0, 0, 0, 0, 0, 1, 32'hC, 32'h44, packExp(0, 1, 0, 0, 1, 2, 4, 4, 0));
    vecs[16] = mk(0, 0, 0, 0, 1, 0, 0, 0,        packExp(0, 0, 0, 3, 0, 0, 0, 4, 0));
    vecs[17] = mk(1, 32'h10, 32'h55, 0, 0, 0, 0, 0, packExp(0, 0, 0, 3, 0, 0, 0, 4, 1));
    vecs[18] = mk(1, 32'h14, 32'h66, 1, 0, 0, 0, 0, packExp(0, 0, 0, 3, 0, 0, 0, 4, 1));
    vecs[19] = mk(0, 0, 0, 1, 0, 0, 0, 0,        packExp(1, 0, 0, 3, 0, 0, 0, 4, 1));
    vecs[20] = mk(0, 0, 0, 0, 0, 1, 32'h1, 32'h11, packExp(1, 0, 0, 3, 1, 0, 1, 4, 1));
    vecs[21] = mk(0, 0, 0, 0, 0, 1, 32'h4, 32'h22, packExp(1, 0, 0, 3, 1, 0, 2, 4, 1));
    vecs[22] = mk(0, 0, 0, 0, 0, 1, 32'h8, 32'h05, packExp(1, 0, 0, 3, 1, 0, 3, 4, 1));
    vecs[23] = mk(0, 0, 0, 0, 0, 1, 32'hC, 32'h44, packExp(0, 1, 0, 0, 1, 0, 4, 4, 1));
    vecs[24] = mk(0, 0, 0, 0, 1, 0, 0, 0,        packExp(0, 0, 0, 3, 0, 0, 0, 4, 1));

    // Reset state.
    Reset = 1'b0;
    applyStimulus(0, 0, 0, 0, 0, 0, 0, 0);
    tick();
    tick();
    checkOutput("reset_state", 64'(observed()), 64'(packExp(0, 0, 0, 3, 0, 0, 0, 0, 0)));
    Reset = 1'b1;
    tick();
    checkOutput("post_reset_idle", 64'(observed()), 64'(packExp(0, 0, 0, 3, 0, 0, 0, 0, 0)));

    // Start with an empty trace is ignored.
    pulseStart();
    checkOutput("start_empty_ignored", 64'(observed()), 64'(packExp(0, 0, 0, 3, 0, 0, 0, 0, 0)));

    for (int i = 0; i < 25; i++) begin
      applyStimulus(vecs[i].ld, vecs[i].ldPC, vecs[i].ldData, vecs[i].st, vecs[i].clr,
                    vecs[i].wv, vecs[i].pc, vecs[i].wd);
      tick();
      checkOutput($sformatf("vec%0d", i), 64'(observed()), 64'(vecs[i].exp));
    end

    // Halt: two commits, then PC frozen at 0x40. The first frozen cycle still
    // differs from the last committed PC, so eight repeats need nine cycles.
    pulseStart();
    commit(tPC[0], tD[0]);
    commit(tPC[1], tD[1]);
    applyStimulus(0, 0, 0, 0, 0, 0, 32'h40, 0);
    n = 0;
    while (!Done && n < 30) begin
      tick();
      n++;
    end
    checkOutput("halt_cycles", 64'(n), 64'd9);
    checkOutput("halt_result", 64'(observed()), 64'(packExp(0, 1, 0, 1, 0, 0, 11, 4, 1)));
    pulseClear();

    // Timeout: PC keeps moving with no commits.
    pulseStart();
    for (int i = 1; i <= 20; i++) begin
      idleCycle(32'h200 + 32'(i) * 4);
      if (i == 19) checkOutput("timeout_not_early", 64'({Busy, Done}), 64'b10);
    end
    checkOutput("timeout_result", 64'(observed()), 64'(packExp(0, 1, 0, 2, 0, 0, 20, 4, 1)));
    pulseClear();

    // Final commit lands on the timeout cycle: completion takes priority.
    pulseStart();
    for (int i = 1; i <= 20; i++) begin
      if (i <= 3) commit(tPC[i-1], tD[i-1]);
      else if (i == 20) commit(tPC[3], tD[3]);
      else idleCycle(32'h200 + 32'(i) * 4);
    end
    checkOutput("coincident_result", 64'(observed()), 64'(packExp(0, 1, 1, 0, 0, 0, 20, 4, 1)));
    pulseClear();

    // Reset in the middle of a run aborts immediately, without waiting for a clock.
    pulseStart();
    commit(tPC[0], tD[0]);
    applyStimulus(0, 0, 0, 0, 0, 0, 0, 0);
    #2;
    Reset = 1'b0;
    #1;
    checkOutput("reset_midrun", 64'(observed()), 64'(packExp(0, 0, 0, 3, 0, 0, 0, 0, 0)));
    tick();
    checkOutput("reset_no_done", 64'(Done), 64'd0);
    Reset = 1'b1;
    tick();

    // Reload, run, Clear, rerun with only Start.
    for (int k = 0; k < 4; k++) begin
      applyStimulus(1, tPC[k], tD[k], 0, 0, 0, 0, 0);
      tick();
    end
    checkOutput("reload_count", 64'(EntryCount), 64'd4);
    runCleanTrace("run_a");
    pulseClear();
    checkOutput("clear_state", 64'(observed()), 64'(packExp(0, 0, 0, 3, 0, 0, 0, 4, 0)));
    runCleanTrace("run_b");

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
